// File: rtl/fpu_op_sequencer_if.sv
// fpu_op_sequencer_if
// Bundles the execute-stage request/response signals and the sub-unit bus
// of the FPU operation sequencer.
//   master : execute stage plus sub-units (drives requests and unit results)
//   slave  : the sequencer itself
// Request side : i_ena, i_unit, i_w32, i_a, i_b, i_flush
// Response side: o_busy, o_ready, o_result, o_ex, o_timeout
// Unit side    : o_u_ena, o_u_a, o_u_b, o_u_w32, i_u_valid, i_u_result, i_u_ex
interface fpu_op_sequencer_if #(
  parameter int NUM_UNITS = 5
);
  logic                     i_ena;
  logic [NUM_UNITS-1:0]     i_unit;
  logic                     i_w32;
  logic [63:0]              i_a;
  logic [63:0]              i_b;
  logic                     i_flush;
  logic                     o_busy;
  logic                     o_ready;
  logic [63:0]              o_result;
  logic [4:0]               o_ex;
  logic                     o_timeout;
  logic [NUM_UNITS-1:0]     o_u_ena;
  logic [63:0]              o_u_a;
  logic [63:0]              o_u_b;
  logic                     o_u_w32;
  logic [NUM_UNITS-1:0]     i_u_valid;
  logic [NUM_UNITS*64-1:0]  i_u_result;
  logic [NUM_UNITS*5-1:0]   i_u_ex;

  modport master (
    output i_ena, i_unit, i_w32, i_a, i_b, i_flush,
    output i_u_valid, i_u_result, i_u_ex,
    input  o_busy, o_ready, o_result, o_ex, o_timeout,
    input  o_u_ena, o_u_a, o_u_b, o_u_w32
  );

  modport slave (
    input  i_ena, i_unit, i_w32, i_a, i_b, i_flush,
    input  i_u_valid, i_u_result, i_u_ex,
    output o_busy, o_ready, o_result, o_ex, o_timeout,
    output o_u_ena, o_u_a, o_u_b, o_u_w32
  );
endinterface

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer
// Runs one double-precision FPU operation at a time on one of the River FPU
// sub-units (fadd=0, fdiv=1, fmul=2, d2l=3, l2d=4). Latches the operands,
// pulses the selected unit's enable for one cycle, waits for its valid and
// hands result plus IEEE flags back with a one-cycle o_ready pulse.
// Ports:
//   i_clk : clock
//   i_rst : asynchronous active-high reset
//   bus   : request/response and sub-unit signals (fpu_op_sequencer_if.slave)
// Flushed operations leave a drain bit for their unit so that a late valid
// from the aborted operation can never be mistaken for a new result.
module fpu_op_sequencer #(
  parameter int NUM_UNITS = 5,
  parameter int TIMEOUT_W = 7
) (
  input  logic               i_clk,
  input  logic               i_rst,
  fpu_op_sequencer_if.slave  bus
);

  localparam logic [4:0] EX_INVALID = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_UNITS-1:0] sel_q, sel_d;
  logic [NUM_UNITS-1:0] drain_q, drain_d, drain_set;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic [63:0]          u_a_q, u_a_d;
  logic [63:0]          u_b_q, u_b_d;
  logic                 u_w32_q, u_w32_d;
  logic [63:0]          result_q, result_d;
  logic [4:0]           ex_q, ex_d;
  logic                 tmo_q, tmo_d;

  logic                 unit_onehot;
  logic                 sel_valid;
  logic [63:0]          sel_result;
  logic [4:0]           sel_ex;

  // A legal request names exactly one unit: non-zero with a single bit set.
  assign unit_onehot = (bus.i_unit != '0) &&
                       ((bus.i_unit & (bus.i_unit - {{(NUM_UNITS-1){1'b0}}, 1'b1})) == '0);

  assign sel_valid = |(bus.i_u_valid & sel_q);
  assign wdog_inc  = wdog_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  // sel is one-hot while waiting, so OR-ing the selected slices is a mux.
  always_comb begin
    sel_result = '0;
    sel_ex     = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (sel_q[k]) begin
        sel_result = sel_result | bus.i_u_result[64*k +: 64];
        sel_ex     = sel_ex | bus.i_u_ex[5*k +: 5];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    drain_set = '0;
    wdog_d    = wdog_q;
    u_a_d     = u_a_q;
    u_b_d     = u_b_q;
    u_w32_d   = u_w32_q;
    result_d  = result_q;
    ex_d      = ex_q;
    tmo_d     = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_ena) begin
          if (!unit_onehot) begin
            result_d = '0;
            ex_d     = EX_INVALID;
            tmo_d    = 1'b0;
            state_d  = ST_DONE;
          end else if ((bus.i_unit & drain_q) == '0) begin
            // A unit still draining a flushed op is simply not accepted;
            // the requester keeps i_ena high until it goes through.
            u_a_d   = bus.i_a;
            u_b_d   = bus.i_b;
            u_w32_d = bus.i_w32;
            sel_d   = bus.i_unit;
            tmo_d   = 1'b0;
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        wdog_d = '0;
        if (bus.i_flush) begin
          drain_set = sel_q;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        wdog_d = wdog_inc;
        if (bus.i_flush) begin
          // A valid in the flush cycle completes the unit, nothing to drain.
          if (!sel_valid) begin
            drain_set = sel_q;
          end
          state_d = ST_IDLE;
        end else if (sel_valid) begin
          result_d = sel_result;
          ex_d     = sel_ex;
          state_d  = ST_DONE;
        end else if (&wdog_inc) begin
          result_d = '0;
          ex_d     = EX_INVALID;
          tmo_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    drain_d = (drain_q & ~bus.i_u_valid) | drain_set;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      drain_q  <= '0;
      wdog_q   <= '0;
      u_a_q    <= '0;
      u_b_q    <= '0;
      u_w32_q  <= 1'b0;
      result_q <= '0;
      ex_q     <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      drain_q  <= drain_d;
      wdog_q   <= wdog_d;
      u_a_q    <= u_a_d;
      u_b_q    <= u_b_d;
      u_w32_q  <= u_w32_d;
      result_q <= result_d;
      ex_q     <= ex_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.o_u_ena   = (state_q == ST_ISSUE) ? sel_q : '0;
  assign bus.o_ready   = (state_q == ST_DONE);
  assign bus.o_timeout = (state_q == ST_DONE) && tmo_q;
  assign bus.o_busy    = (state_q != ST_IDLE) || (drain_q != '0);
  assign bus.o_result  = result_q;
  assign bus.o_ex      = ex_q;
  assign bus.o_u_a     = u_a_q;
  assign bus.o_u_b     = u_b_q;
  assign bus.o_u_w32   = u_w32_q;

endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
- Sequences one double-precision FPU operation at a time across the River FPU sub-units: fadd, fdiv, fmul, d2l and l2d.
- Latches the request operands and issues a one-cycle enable to exactly one sub-unit, then waits for that unit's valid.
- Captures the result and the five IEEE exception flags, and returns them to the execute stage with a one-cycle ready pulse.
- Handles illegal requests, pipeline flush with in-flight drain tracking, and a watchdog timeout.

Parameters:
- NUM_UNITS, 5, number of sub-units; bit order fadd=0, fdiv=1, fmul=2, d2l=3, l2d=4.
- TIMEOUT_W, 7, watchdog counter width; timeout fires at 2^TIMEOUT_W-1 WAIT cycles.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_ena  in  1  request valid; sampled only in IDLE.
- i_unit  in  NUM_UNITS  one-hot sub-unit select.
- i_w32  in  1  32-bit operand mode, forwarded to the unit.
- i_a  in  64  operand A.
- i_b  in  64  operand B.
- i_flush  in  1  abort the current operation.
- o_busy  out  1  sequencer not IDLE, or any drain bit set.
- o_ready  out  1  one-cycle result-valid pulse.
- o_result  out  64  result, held until the next o_ready.
- o_ex  out  5  exception flags {invalidop, divbyzero, overflow, underflow, inexact}, held with o_result.
- o_timeout  out  1  pulses with o_ready when the watchdog fired.
- o_u_ena  out  NUM_UNITS  one-cycle enable to the sub-units.
- o_u_a  out  64  registered operand A to the units.
- o_u_b  out  64  registered operand B to the units.
- o_u_w32  out  1  registered w32 to the units.
- i_u_valid  in  NUM_UNITS  per-unit result valid.
- i_u_result  in  NUM_UNITS*64  per-unit result; unit k occupies bits [64k+63:64k].
- i_u_ex  in  NUM_UNITS*5  per-unit exception flags; unit k occupies bits [5k+4:5k].

Behaviour:
- Reset (asynchronous, while i_rst=1):
  - State goes to IDLE.
  - All outputs go to 0; sel, drain mask and watchdog counter go to 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - A request is accepted when i_ena=1, i_unit is exactly one-hot, and (i_unit & drain)==0.
  - On accept: latch i_a, i_b, i_w32 into o_u_a, o_u_b, o_u_w32 and i_unit into sel; go to ISSUE.
  - If i_ena=1 and i_unit is zero or multi-hot: o_result=0, o_ex=5'b10000; go to DONE. No unit is enabled.
  - If i_ena=1 and the target unit's drain bit is set: the request is not accepted and stays in IDLE. The requester holds it while o_busy=1.
- ISSUE:
  - o_u_ena=sel for exactly this cycle.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - When i_u_valid & sel is nonzero: capture that unit's result and flags into o_result/o_ex; go to DONE.
  - Valids from non-selected units are ignored.
  - The watchdog counter increments each WAIT cycle. On reaching 2^TIMEOUT_W-1 without a valid: o_result=0, o_ex=5'b10000, timeout flag set; go to DONE.
- DONE:
  - o_ready=1 for this cycle only, plus o_timeout if the watchdog fired.
  - Return to IDLE. A new request is accepted no earlier than the following cycle.
- Latency: request accepted at cycle N, o_u_ena at N+1. If the unit's valid arrives at cycle V (V≥N+2), o_ready is at V+1. Minimum latency is 3 cycles. Illegal request: o_ready at N+1.
- Flush:
  - i_flush=1 in ISSUE or WAIT: next state IDLE, no o_ready, o_result/o_ex unchanged.
  - If flushed in ISSUE: o_u_ena is still issued that cycle, and the sel bit is set in drain.
  - If flushed in WAIT with no valid from sel that cycle: the sel bit is set in drain.
  - Flush and valid from sel in the same WAIT cycle: flush wins; drain is not set and the result is discarded.
  - i_flush in IDLE or DONE has no effect; DONE's o_ready still fires.
- Drain: a drain bit clears when the corresponding i_u_valid is seen, in any state. A watchdog timeout does not set drain.
- o_busy = (state != IDLE) | (drain != 0).
- Reset mid-operation: immediate return to IDLE with drain cleared. The sub-units are reset by the same i_rst.

Test Plan:
- fadd request, a=0x3FF0000000000000, b=0x4000000000000000; unit 0 valid 2 cycles after its enable with result 0x4008000000000000, ex=0 -> o_u_ena=5'b00001 at N+1 only; o_ready at N+4 with o_result=0x4008000000000000, o_ex=0.
- i_unit=5'b00110 with i_ena -> no o_u_ena; o_ready at N+1 with o_result=0, o_ex=5'b10000.
- fdiv request, unit 1 never valid, TIMEOUT_W=7 -> o_ready and o_timeout together after 127 WAIT cycles, o_ex=5'b10000, o_busy=0 afterwards.
- fmul request, i_flush 3 cycles after issue -> no o_ready, o_busy stays 1. A new fmul request is held off until unit 2 valid; fadd requests are still accepted once IDLE.
- In WAIT, i_flush and i_u_valid[sel] in the same cycle -> no o_ready, drain=0, o_busy=0 next cycle.
- i_rst asserted mid-WAIT with drain bit 3 set -> all outputs 0 and drain=0 immediately; normal fadd completes after i_rst deasserts.
